// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the memory-side signals of the data-memory arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface dmem_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [3:0]  p0_be;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;

    logic        p1_req;
    logic        p1_we;
    logic [3:0]  p1_be;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_lock;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  p0_req, p0_we, p0_be, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_be, p1_addr, p1_wdata, p1_lock,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_we, mem_be, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output p0_req, p0_we, p0_be, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_we, p1_be, p1_addr, p1_wdata, p1_lock,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_we, mem_be, mem_a, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin (or fixed-priority) arbiter for a single-ported word memory,
// with a port-1 bus lock, out-of-range write suppression and one-cycle read responses.
module dmem_arbiter #(
    parameter int DEPTH = 64,
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic {ARB, LOCKED1} state_t;

    state_t      state, state_nxt;
    logic        last_gnt;
    logic        gnt0, gnt1;
    logic        p0_oor, p1_oor;
    logic        rvalid0, rvalid1;
    logic        err0, err1;
    logic [31:0] rdata0, rdata1;

    assign p0_oor = (bus.p0_addr[31:2] >= DEPTH_W);
    assign p1_oor = (bus.p1_addr[31:2] >= DEPTH_W);

    // Grants are withheld while reset is high so the reset-cycle outputs are all zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        if (!reset) begin
            unique case (state)
                ARB: begin
                    if (bus.p0_req && bus.p1_req) begin
                        if (RR_EN && !last_gnt) gnt1 = 1'b1;
                        else                    gnt0 = 1'b1;
                    end else begin
                        gnt0 = bus.p0_req;
                        gnt1 = bus.p1_req;
                    end
                    if (gnt1 && bus.p1_lock) state_nxt = LOCKED1;
                end
                LOCKED1: begin
                    gnt1 = bus.p1_req;
                    if (!bus.p1_lock) state_nxt = ARB;
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    always_comb begin
        bus.mem_we = 1'b0;
        bus.mem_be = 4'b0000;
        bus.mem_a  = 32'h0;
        bus.mem_wd = 32'h0;
        if (gnt0) begin
            bus.mem_we = bus.p0_we & ~p0_oor;
            bus.mem_be = p0_oor ? 4'b0000 : bus.p0_be;
            bus.mem_a  = bus.p0_addr;
            bus.mem_wd = bus.p0_wdata;
        end else if (gnt1) begin
            bus.mem_we = bus.p1_we & ~p1_oor;
            bus.mem_be = p1_oor ? 4'b0000 : bus.p1_be;
            bus.mem_a  = bus.p1_addr;
            bus.mem_wd = bus.p1_wdata;
        end
    end

    // rdata/err only load on that port's own grant, so they hold until its next response.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (reset) begin
            state    <= ARB;
            last_gnt <= 1'b1;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= 32'h0;
            rdata1   <= 32'h0;
            err0     <= 1'b0;
            err1     <= 1'b0;
        end else begin
            state   <= state_nxt;
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            if (gnt0) begin
                last_gnt <= 1'b0;
                rdata0   <= (bus.p0_we || p0_oor) ? 32'h0 : bus.mem_rd;
                err0     <= p0_oor;
            end
            if (gnt1) begin
                last_gnt <= 1'b1;
                rdata1   <= (bus.p1_we || p1_oor) ? 32'h0 : bus.mem_rd;
                err1     <= p1_oor;
            end
        end
    end

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.p0_rvalid = rvalid0;
    assign bus.p1_rvalid = rvalid1;
    assign bus.p0_rdata  = rdata0;
    assign bus.p1_rdata  = rdata1;
    assign bus.p0_err    = err0;
    assign bus.p1_err    = err1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance on a 64-word memory model,
// plus a fixed-priority instance fed the same requests.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [64];

    dmem_arbiter_if bus ();
    dmem_arbiter_if fp ();

    dmem_arbiter #(.DEPTH(64), .RR_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
    dmem_arbiter #(.DEPTH(64), .RR_EN(1'b0)) dut_fp (.clk(clk), .reset(reset), .bus(fp));

    always #5 clk = ~clk;

    assign bus.mem_rd = mem[bus.mem_a[7:2]];
    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) mem[bus.mem_a[7:2]][8*b +: 8] <= bus.mem_wd[8*b +: 8];
        end
    end

    assign fp.p0_req   = bus.p0_req;
    assign fp.p0_we    = bus.p0_we;
    assign fp.p0_be    = bus.p0_be;
    assign fp.p0_addr  = bus.p0_addr;
    assign fp.p0_wdata = bus.p0_wdata;
    assign fp.p1_req   = bus.p1_req;
    assign fp.p1_we    = bus.p1_we;
    assign fp.p1_be    = bus.p1_be;
    assign fp.p1_addr  = bus.p1_addr;
    assign fp.p1_wdata = bus.p1_wdata;
    assign fp.p1_lock  = bus.p1_lock;
    assign fp.mem_rd   = 32'h0;

    task automatic set_p0(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus.p0_req = req; bus.p0_we = we; bus.p0_be = be;
        bus.p0_addr = addr; bus.p0_wdata = wdata;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
        bus.p1_req = req; bus.p1_we = we; bus.p1_be = be;
        bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_lock = lock;
    endtask

    task automatic idle();
        set_p0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err,
             bus.mem_we, bus.mem_be} !== 11'b0) begin
            errors++;
            $display("FAIL %s flags: got gnt=%b%b rvalid=%b%b err=%b%b we=%b be=%b, want all 0", name,
                     bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err,
                     bus.mem_we, bus.mem_be);
        end
        checks++;
        if ({bus.p0_rdata, bus.p1_rdata, bus.mem_a, bus.mem_wd} !== 128'h0) begin
            errors++;
            $display("FAIL %s data: got rdata0=%h rdata1=%h mem_a=%h mem_wd=%h, want 0", name,
                     bus.p0_rdata, bus.p1_rdata, bus.mem_a, bus.mem_wd);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        set_p0(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        set_p1(1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            exp = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({bus.p0_gnt, bus.p1_gnt} !== exp) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got {p0,p1}=%b, want %b", i, {bus.p0_gnt, bus.p1_gnt}, exp);
            end
            checks++;
            if ({fp.p0_gnt, fp.p1_gnt} !== 2'b10) begin
                errors++;
                $display("FAIL fixed_grant[%0d]: got {p0,p1}=%b, want 10", i, {fp.p0_gnt, fp.p1_gnt});
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_read();
        set_p0(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        #1;
        checks++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.mem_we, bus.mem_a} !== {3'b100, 32'h8}) begin
            errors++;
            $display("FAIL read_grant: got gnt=%b%b we=%b a=%h, want gnt=10 we=0 a=00000008",
                     bus.p0_gnt, bus.p1_gnt, bus.mem_we, bus.mem_a);
        end
        @(posedge clk); #1;
        idle();
        checks++;
        if ({bus.p0_rvalid, bus.p0_err, bus.p0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL read_resp: got rvalid=%b err=%b rdata=%h, want 1 0 deadbeef",
                     bus.p0_rvalid, bus.p0_err, bus.p0_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL read_hold: got rvalid=%b rdata=%h, want 0 deadbeef", bus.p0_rvalid, bus.p0_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_byte_write();
        set_p1(1'b1, 1'b1, 4'b0011, 32'h10, 32'h12345678, 1'b0);
        #1;
        checks++;
        if ({bus.p1_gnt, bus.mem_we, bus.mem_be, bus.mem_a, bus.mem_wd} !== {2'b11, 4'b0011, 32'h10, 32'h12345678}) begin
            errors++;
            $display("FAIL be_write_bus: got gnt=%b we=%b be=%b a=%h wd=%h, want 1 1 0011 00000010 12345678",
                     bus.p1_gnt, bus.mem_we, bus.mem_be, bus.mem_a, bus.mem_wd);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.p1_rvalid, bus.p1_err, bus.p1_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL be_write_ack: got rvalid=%b err=%b rdata=%h, want 1 0 00000000",
                     bus.p1_rvalid, bus.p1_err, bus.p1_rdata);
        end
        @(negedge clk);
        idle();
        set_p0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        @(posedge clk); #1;
        idle();
        checks++;
        if ({bus.p0_rvalid, bus.p0_rdata} !== {1'b1, 32'hAAAA5678}) begin
            errors++;
            $display("FAIL be_readback: got rvalid=%b rdata=%h, want 1 aaaa5678", bus.p0_rvalid, bus.p0_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_lock();
        for (int c = 0; c < 3; c++) begin
            set_p0(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
            set_p1(1'b1, 1'b1, 4'hF, 32'h20 + 32'(4 * c), 32'hC0DE0000 + 32'(c), 1'b1);
            #1;
            checks++;
            if ({bus.p0_gnt, bus.p1_gnt} !== 2'b01) begin
                errors++;
                $display("FAIL lock_hold[%0d]: got {p0,p1}=%b, want 01", c, {bus.p0_gnt, bus.p1_gnt});
            end
            @(negedge clk);
        end
        set_p1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if ({bus.p0_gnt, bus.p1_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL lock_drop_cycle: got {p0,p1}=%b, want 00", {bus.p0_gnt, bus.p1_gnt});
        end
        @(negedge clk);
        set_p1(1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
        #1;
        checks++;
        if ({bus.p0_gnt, bus.p1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL unlock_grant: got {p0,p1}=%b, want 10", {bus.p0_gnt, bus.p1_gnt});
        end
        @(negedge clk);
        idle();
        checks++;
        if (mem[10] !== 32'hC0DE0002) begin
            errors++;
            $display("FAIL lock_write_data: got mem[10]=%h, want c0de0002", mem[10]);
        end
    endtask

    task automatic test_out_of_range();
        set_p0(1'b1, 1'b1, 4'hF, 32'h100, 32'hFFFFFFFF);
        #1;
        checks++;
        if ({bus.p0_gnt, bus.mem_we, bus.mem_be} !== 6'b100000) begin
            errors++;
            $display("FAIL oor_bus: got gnt=%b we=%b be=%b, want 1 0 0000", bus.p0_gnt, bus.mem_we, bus.mem_be);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.p0_rvalid, bus.p0_err, bus.p0_rdata} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL oor_resp: got rvalid=%b err=%b rdata=%h, want 1 1 00000000",
                     bus.p0_rvalid, bus.p0_err, bus.p0_rdata);
        end
        checks++;
        if (mem[0] !== 32'h10000000) begin
            errors++;
            $display("FAIL oor_no_write: got mem[0]=%h, want 10000000", mem[0]);
        end
        @(negedge clk);
        set_p0(1'b1, 1'b0, 4'hF, 32'hFC, 32'h0);
        @(posedge clk); #1;
        idle();
        checks++;
        if ({bus.p0_rvalid, bus.p0_err, bus.p0_rdata} !== {2'b10, 32'h1000003F}) begin
            errors++;
            $display("FAIL last_word_read: got rvalid=%b err=%b rdata=%h, want 1 0 1000003f",
                     bus.p0_rvalid, bus.p0_err, bus.p0_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        set_p0(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        @(posedge clk); #1;
        idle();
        reset = 1'b1;
        checks++;
        if (bus.p0_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_rvalid: got %b, want 1", bus.p0_rvalid);
        end
        @(posedge clk); #1;
        check_reset_values("reset_after_grant");
        @(negedge clk);
        reset = 1'b0;
        set_p1(1'b1, 1'b1, 4'hF, 32'h30, 32'h55, 1'b1);
        @(posedge clk); #1;
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("reset_in_lock");
        @(negedge clk);
        reset = 1'b0;
        set_p0(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        set_p1(1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
        #1;
        checks++;
        if ({bus.p0_gnt, bus.p1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL lock_released_by_reset: got {p0,p1}=%b, want 10", {bus.p0_gnt, bus.p1_gnt});
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h10000000 + 32'(i);
        mem[2] = 32'hDEADBEEF;
        mem[4] = 32'hAAAABBBB;
        test_reset();
        test_round_robin();
        test_read();
        test_byte_write();
        test_lock();
        test_out_of_range();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported, word-addressed data memory between two requesters.
  - Port 0: core load/store unit.
  - Port 1: debug/loader port.
- Performs round-robin arbitration with a valid/grant handshake.
- Drives the memory's write-enable, byte-enable, address and write-data inputs, and returns registered read data with a fixed one-cycle latency.
- Supports a bus lock so port 1 can perform uninterrupted multi-word sequences. Also supports an out-of-range address check that suppresses writes.

Parameters:
- DEPTH, 64: memory depth in 32-bit words. Word addresses at or above DEPTH are out of range. Must be a power of two.
- RR_EN, 1: 1 selects round-robin arbitration. 0 selects fixed priority, with port 0 always winning.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- p0_req  in  1  port 0 access request
- p0_we  in  1  port 0 write (1) / read (0)
- p0_be  in  4  port 0 byte enables; bit i selects byte lane i
- p0_addr  in  32  port 0 byte address; bits [1:0] ignored
- p0_wdata  in  32  port 0 write data
- p0_gnt  out  1  port 0 request accepted this cycle
- p0_rvalid  out  1  port 0 response valid
- p0_rdata  out  32  port 0 read data
- p0_err  out  1  port 0 out-of-range error, qualified by p0_rvalid
- p1_req, p1_we, p1_be, p1_addr, p1_wdata  in  1/1/4/32/32  port 1 equivalents of the port 0 inputs
- p1_lock  in  1  port 1 bus-lock request
- p1_gnt, p1_rvalid, p1_rdata, p1_err  out  1/1/32/1  port 1 equivalents of the port 0 outputs
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_a  out  32  memory byte address
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory combinational read data (word at mem_a)

Behaviour:
- Reset: the following values hold in the cycle after reset is sampled high.
  - State is ARB; the round-robin pointer last_gnt = 1, so port 0 has priority first.
  - All gnt, rvalid and err outputs are 0; rdata is 0.
  - mem_we = 0, mem_be = 0, mem_a = 0, mem_wd = 0.
- Grant is combinational within the request cycle.
  - At most one gnt is high per cycle.
  - A requester holds req and its request fields stable until it sees gnt.
- mem_* are driven combinationally from the winner's fields in the grant cycle.
  - mem_be = be and mem_we = we, both forced to 0 when the address is out of range.
  - With no grant: mem_we = 0, mem_be = 0, mem_a = 0, mem_wd = 0.
- Out of range means addr[31:2] >= DEPTH. The winner still receives gnt and an rvalid response, with err = 1 and rdata = 0. Memory is never written.
- Response timing:
  - On the grant edge, the arbiter registers winner id, mem_rd and err.
  - In cycle N+1, the granted port sees rvalid = 1 for exactly one cycle.
  - For writes, rdata = 0 and the response is an acknowledge only.
  - rdata and err hold their value until the next response to that port.
- Back-to-back grants, one per cycle, are allowed. Throughput is one access per cycle.
- State ARB:
  - Only p0_req: grant 0. Only p1_req: grant 1.
  - Both requests with RR_EN = 1: grant the port that is not last_gnt.
  - Both requests with RR_EN = 0: grant 0.
  - last_gnt updates to the winner on every grant.
  - On a port 1 grant with p1_lock = 1, go to LOCKED1.
- State LOCKED1:
  - Only port 1 can be granted; p0_req is held off with p0_gnt = 0.
  - Stay in LOCKED1 while p1_lock = 1.
  - If p1_lock = 0 in any cycle, return to ARB next cycle. A port 1 grant in that same cycle still completes.
  - last_gnt remains 1 on leaving, so port 0 wins the first contested cycle after unlock.
- p1_lock is ignored unless it accompanies a port 1 grant. p0 has no lock.
- Reset mid-operation: any pending rvalid is dropped (not delivered), the lock is released and the state returns to ARB. Requesters must re-issue.

Test Plan:
- Reset, then p0 read at addr 0x8 with mem word 2 = 0xDEADBEEF:
  - p0_gnt = 1 in the same cycle; mem_a = 0x8, mem_we = 0.
  - Next cycle: p0_rvalid = 1, p0_rdata = 0xDEADBEEF, err = 0.
- Both ports request continuously for 4 cycles, RR_EN = 1:
  - Grant sequence 0, 1, 0, 1.
  - With RR_EN = 0: 0, 0, 0, 0, and p1 is never granted.
- p1 write to addr 0x10, be = 4'b0011, wdata = 0x12345678:
  - mem_we = 1, mem_be = 0011 in the grant cycle.
  - A following p0 read of 0x10 returns the upper halfword unchanged and lower halfword 0x5678.
- p1 asserts lock with 3 writes while p0_req is high throughout:
  - p0_gnt = 0 for those 3 cycles.
  - p0 is granted in the first cycle after p1_lock drops.
- p0 write to addr 0x100 (word 64) with DEPTH = 64:
  - mem_we = 0 and mem_be = 0 in the grant cycle.
  - Next cycle: p0_rvalid = 1, p0_err = 1, p0_rdata = 0.
- Assert reset in the cycle after a p0 grant:
  - p0_rvalid = 0, state returns to ARB, and all outputs match reset values next cycle.
